// File: rtl/mips_pkg.sv
// Shared constants and types for the MIPS core pipeline registers.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package mips_pkg;

  localparam logic [4:0]  EXC_NONE   = 5'd0;
  localparam logic [4:0]  EXC_ADEL   = 5'd4;
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0000;
  localparam logic [31:0] HANDLER_PC_DEFAULT = 32'h0000_4180;
  localparam logic [31:0] RESET_PC_DEFAULT   = 32'h0000_3000;

  typedef enum logic {
    RUN       = 1'b0,
    ERET_WAIT = 1'b1
  } fd_state_t;

endpackage

// File: rtl/fd_perf_cnt.sv
// Stall and bubble event counters for the F->D register; wrap at 2^32.
// Latency: count visible one cycle after the event edge.
// Backpressure: none; counts every qualified edge.
module fd_perf_cnt (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall_evt,
  input  logic        bubble_evt,
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt
);

  // Free-running event counters, cleared by the core reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (stall_evt)  stall_cnt  <= stall_cnt + 32'd1;
      if (bubble_evt) bubble_cnt <= bubble_cnt + 32'd1;
    end
  end

endmodule

// File: rtl/fd_pipe_reg.sv
// F->D pipeline register: stall/flush/exception squash, delay-slot and ERET tracking.
// Latency: one cycle F->D, outputs come straight from flops.
// Backpressure: EN=0 holds everything; ExcReq and flush override a stall.
// Optional FD_PERF_CNT_EN adds stall_cnt/bubble_cnt outputs.
module fd_pipe_reg
  import mips_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC = HANDLER_PC_DEFAULT,
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        EN,
  input  logic        flush,
  input  logic        ExcReq,
  input  logic [31:0] F_Instr,
  input  logic [31:0] F_PC,
  input  logic [4:0]  F_ExcCode,
  input  logic        F_isBranch,
  input  logic        F_isERET,
`ifdef FD_PERF_CNT_EN
  output logic [31:0] stall_cnt,
  output logic [31:0] bubble_cnt,
`endif
  output logic [31:0] D_Instr,
  output logic [31:0] D_PC,
  output logic [4:0]  D_ExcCode,
  output logic        D_BD,
  output logic        D_isERET,
  output logic        D_valid
);

  fd_state_t   state, state_nxt;
  logic        prev_branch, prev_branch_nxt;
  logic [31:0] instr_nxt, pc_nxt;
  logic [4:0]  exc_nxt;
  logic        bd_nxt, eret_nxt, valid_nxt;
  logic        stall_evt, bubble_evt;

  // Next-state selection in priority order: exception > flush > hold > load.
  // The load after an ERET is the wrong-path fetch and becomes a bubble; prev_branch
  // is left alone on bubbles so the delay slot is not consumed.
  always_comb begin
    state_nxt       = state;
    prev_branch_nxt = prev_branch;
    instr_nxt       = D_Instr;
    pc_nxt          = D_PC;
    exc_nxt         = D_ExcCode;
    bd_nxt          = D_BD;
    eret_nxt        = D_isERET;
    valid_nxt       = D_valid;
    stall_evt       = 1'b0;
    bubble_evt      = 1'b0;
    if (ExcReq) begin
      instr_nxt = NOP_INSTR; exc_nxt = EXC_NONE; bd_nxt = 1'b0;
      eret_nxt  = 1'b0;      valid_nxt = 1'b0;   pc_nxt = HANDLER_PC;
      prev_branch_nxt = 1'b0;
      state_nxt       = RUN;
      bubble_evt      = 1'b1;
    end else if (flush) begin
      instr_nxt = NOP_INSTR; exc_nxt = EXC_NONE; bd_nxt = 1'b0;
      eret_nxt  = 1'b0;      valid_nxt = 1'b0;   pc_nxt = F_PC;
      prev_branch_nxt = 1'b0;
      bubble_evt      = 1'b1;
    end else if (!EN) begin
      stall_evt = 1'b1;
    end else if (state == ERET_WAIT) begin
      instr_nxt = NOP_INSTR; exc_nxt = EXC_NONE; bd_nxt = 1'b0;
      eret_nxt  = 1'b0;      valid_nxt = 1'b0;   pc_nxt = F_PC;
      state_nxt  = RUN;
      bubble_evt = 1'b1;
    end else begin
      instr_nxt = F_Instr;   exc_nxt = F_ExcCode; bd_nxt = prev_branch;
      eret_nxt  = F_isERET;  valid_nxt = 1'b1;    pc_nxt = F_PC;
      prev_branch_nxt = F_isBranch;
      state_nxt       = F_isERET ? ERET_WAIT : RUN;
    end
  end

  // Pipeline register and FSM state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= RUN;
      prev_branch <= 1'b0;
      D_Instr     <= NOP_INSTR;
      D_PC        <= RESET_PC;
      D_ExcCode   <= EXC_NONE;
      D_BD        <= 1'b0;
      D_isERET    <= 1'b0;
      D_valid     <= 1'b0;
    end else begin
      state       <= state_nxt;
      prev_branch <= prev_branch_nxt;
      D_Instr     <= instr_nxt;
      D_PC        <= pc_nxt;
      D_ExcCode   <= exc_nxt;
      D_BD        <= bd_nxt;
      D_isERET    <= eret_nxt;
      D_valid     <= valid_nxt;
    end
  end

`ifdef FD_PERF_CNT_EN
  fd_perf_cnt u_perf (
    .clk        (clk),
    .reset      (reset),
    .stall_evt  (stall_evt),
    .bubble_evt (bubble_evt),
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt)
  );
`else
  // Event strobes only feed the optional counters.
  logic unused_evt;
  assign unused_evt = stall_evt ^ bubble_evt;
`endif

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Directed bench for fd_pipe_reg: delay slot, stall, flush, exception, ERET squash, reset.
// Latency: checks taken 1 time unit after each rising edge.
// Backpressure: EN toggled explicitly by the directed steps.
module tb_fd_pipe_reg;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        EN = 1'b0, flush = 1'b0, ExcReq = 1'b0;
  logic [31:0] F_Instr = 32'h0, F_PC = 32'h0;
  logic [4:0]  F_ExcCode = 5'd0;
  logic        F_isBranch = 1'b0, F_isERET = 1'b0;
  logic [31:0] D_Instr, D_PC;
  logic [4:0]  D_ExcCode;
  logic        D_BD, D_isERET, D_valid;
`ifdef FD_PERF_CNT_EN
  logic [31:0] stall_cnt, bubble_cnt;
`endif

  int ncmp = 0;
  int nfail = 0;

  localparam logic [31:0] BEQ  = 32'h1000_0003;
  localparam logic [31:0] ADDU = 32'h0043_0821;
  localparam logic [31:0] ORI  = 32'h3421_0001;
  localparam logic [31:0] ERET = 32'h4200_0018;

  fd_pipe_reg dut (
    .clk        (clk),
    .reset      (reset),
    .EN         (EN),
    .flush      (flush),
    .ExcReq     (ExcReq),
    .F_Instr    (F_Instr),
    .F_PC       (F_PC),
    .F_ExcCode  (F_ExcCode),
    .F_isBranch (F_isBranch),
    .F_isERET   (F_isERET),
`ifdef FD_PERF_CNT_EN
    .stall_cnt  (stall_cnt),
    .bubble_cnt (bubble_cnt),
`endif
    .D_Instr    (D_Instr),
    .D_PC       (D_PC),
    .D_ExcCode  (D_ExcCode),
    .D_BD       (D_BD),
    .D_isERET   (D_isERET),
    .D_valid    (D_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of F-side inputs, then sample just after the edge.
  task automatic step(input logic en, input logic fl, input logic exc,
                      input logic [31:0] instr, input logic [31:0] pc,
                      input logic [4:0] ec, input logic br, input logic er);
    EN = en; flush = fl; ExcReq = exc;
    F_Instr = instr; F_PC = pc; F_ExcCode = ec; F_isBranch = br; F_isERET = er;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_d(input string tag, input logic [31:0] instr, input logic [31:0] pc,
                       input logic [4:0] ec, input logic bd, input logic er, input logic vld);
    chk({tag, ".instr"}, D_Instr, instr);
    chk({tag, ".pc"},    D_PC, pc);
    chk({tag, ".exc"},   {27'd0, D_ExcCode}, {27'd0, ec});
    chk({tag, ".bd"},    {31'd0, D_BD}, {31'd0, bd});
    chk({tag, ".eret"},  {31'd0, D_isERET}, {31'd0, er});
    chk({tag, ".valid"}, {31'd0, D_valid}, {31'd0, vld});
  endtask

  initial begin
    // Reset state.
    #12;
    chk_d("reset", 32'h0, 32'h0000_3000, 5'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Delay slot: beq, its slot, then a normal instruction.
    step(1, 0, 0, BEQ,  32'h0000_3000, 5'd0, 1, 0);
    chk_d("beq",  BEQ,  32'h0000_3000, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1, 0, 0, ADDU, 32'h0000_3004, 5'd0, 0, 0);
    chk_d("slot", ADDU, 32'h0000_3004, 5'd0, 1'b1, 1'b0, 1'b1);
    step(1, 0, 0, ORI,  32'h0000_3008, 5'd0, 0, 0);
    chk_d("after_slot", ORI, 32'h0000_3008, 5'd0, 1'b0, 1'b0, 1'b1);

    // Stall between a branch and its slot: outputs held, slot survives.
    step(1, 0, 0, BEQ,  32'h0000_300c, 5'd0, 1, 0);
    step(0, 0, 0, ADDU, 32'h0000_3010, 5'd0, 0, 0);
    chk_d("stall1", BEQ, 32'h0000_300c, 5'd0, 1'b0, 1'b0, 1'b1);
    step(0, 0, 0, ORI,  32'h0000_3010, 5'd0, 0, 0);
    chk_d("stall2", BEQ, 32'h0000_300c, 5'd0, 1'b0, 1'b0, 1'b1);
    step(1, 0, 0, ADDU, 32'h0000_3010, 5'd0, 0, 0);
    chk_d("slot_after_stall", ADDU, 32'h0000_3010, 5'd0, 1'b1, 1'b0, 1'b1);

    // Exception entry overrides stall and flush; pending slot is discarded.
    step(1, 0, 0, BEQ,  32'h0000_3014, 5'd0, 1, 0);
    step(0, 1, 1, ADDU, 32'h0000_3018, 5'd0, 0, 0);
    chk_d("exc", 32'h0, 32'h0000_4180, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1, 0, 0, ORI,  32'h0000_4180, 5'd0, 0, 0);
    chk_d("after_exc", ORI, 32'h0000_4180, 5'd0, 1'b0, 1'b0, 1'b1);

    // Flush overrides stall: bubble carrying F_PC.
    step(0, 1, 0, ADDU, 32'h0000_4184, 5'd3, 1, 1);
    chk_d("flush", 32'h0, 32'h0000_4184, 5'd0, 1'b0, 1'b0, 1'b0);

    // ERET then wrong-path fetch squashed; a stall in between keeps the squash pending.
    step(1, 0, 0, ERET, 32'h0000_4200, 5'd0, 0, 1);
    chk_d("eret", ERET, 32'h0000_4200, 5'd0, 1'b0, 1'b1, 1'b1);
    step(0, 0, 0, ADDU, 32'h0000_4204, 5'd0, 0, 0);
    chk_d("eret_hold", ERET, 32'h0000_4200, 5'd0, 1'b0, 1'b1, 1'b1);
    step(1, 0, 0, ADDU, 32'h0000_4204, 5'd0, 0, 0);
    chk_d("eret_squash", 32'h0, 32'h0000_4204, 5'd0, 1'b0, 1'b0, 1'b0);
    step(1, 0, 0, ORI,  32'h0000_3100, 5'd0, 0, 0);
    chk_d("after_eret", ORI, 32'h0000_3100, 5'd0, 1'b0, 1'b0, 1'b1);

    // Fetch exception on a branch: code carried and the slot still opens.
    step(1, 0, 0, BEQ,  32'h0000_3001, 5'd4, 1, 0);
    chk_d("adel", BEQ, 32'h0000_3001, 5'd4, 1'b0, 1'b0, 1'b1);
    step(0, 0, 0, ADDU, 32'h0000_3005, 5'd0, 0, 0);
    step(0, 0, 0, ADDU, 32'h0000_3005, 5'd0, 0, 0);
    step(0, 0, 0, ADDU, 32'h0000_3005, 5'd0, 0, 0);
    chk_d("adel_hold", BEQ, 32'h0000_3001, 5'd4, 1'b0, 1'b0, 1'b1);
    step(1, 0, 0, ADDU, 32'h0000_3005, 5'd0, 0, 0);
    chk_d("adel_slot", ADDU, 32'h0000_3005, 5'd0, 1'b1, 1'b0, 1'b1);

`ifdef FD_PERF_CNT_EN
    // Stalls: 2 + 1 (eret hold) + 3 = 6. Bubbles: exc, flush, eret squash = 3.
    chk("stall_cnt",  stall_cnt,  32'd6);
    chk("bubble_cnt", bubble_cnt, 32'd3);
`endif

    // Asynchronous reset mid-cycle: takes effect without a clock edge.
    EN = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    chk_d("async_reset", 32'h0, 32'h0000_3000, 5'd0, 1'b0, 1'b0, 1'b0);
`ifdef FD_PERF_CNT_EN
    chk("stall_cnt_rst",  stall_cnt,  32'd0);
    chk("bubble_cnt_rst", bubble_cnt, 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
